// File: rtl/demux_3bit_1to5_reg.sv
// Registered 1-to-5 demultiplexer steering a 3-bit value into slots U..Y.
// Define DEMUX_SEQ_LOAD_EN to add the sequential-load mode (LOAD/DONE states, pointer).
module demux_3bit_1to5_reg (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] data_in,
  input  logic [2:0] sel,
  input  logic       wr_en,
  input  logic       seq_start,
  output logic [2:0] out_u,
  output logic [2:0] out_v,
  output logic [2:0] out_w,
  output logic [2:0] out_x,
  output logic [2:0] out_y,
  output logic       wr_ack,
  output logic       seq_busy,
  output logic       seq_done
);

  localparam int unsigned DW = 3;
  localparam int unsigned NSLOT = 5;
  localparam int unsigned PW = 3;
  localparam logic [PW-1:0] LAST_PTR = PW'(NSLOT - 1);

  logic [PW-1:0]    sel_idx;
  logic [PW-1:0]    wr_idx;
  logic             wr_go;
  logic [NSLOT-1:0] slot_we;

  // sel[2] overrides the low bits so 1xx all map to Y, as the selector reads them
  assign sel_idx = sel[2] ? LAST_PTR : {1'b0, sel[1:0]};

`ifdef DEMUX_SEQ_LOAD_EN
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;

  always_comb begin
    wr_go  = 1'b0;
    wr_idx = sel_idx;
    unique case (state)
      IDLE: begin
        wr_go  = wr_en && !seq_start;
        wr_idx = sel_idx;
      end
      LOAD: begin
        wr_go  = wr_en;
        wr_idx = ptr;
      end
      default: begin
        wr_go  = 1'b0;
        wr_idx = sel_idx;
      end
    endcase
  end

  // Sequencer: state, pointer and all handshake outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      wr_ack   <= 1'b0;
      seq_busy <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      wr_ack   <= wr_go;
      seq_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (seq_start) begin
            state    <= LOAD;
            ptr      <= '0;
            seq_busy <= 1'b1;
          end
        end
        LOAD: begin
          if (wr_en) begin
            if (ptr == LAST_PTR) begin
              state    <= DONE;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end else begin
              ptr <= ptr + PW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
`else
  logic unused_seq_start;

  assign unused_seq_start = seq_start;
  assign wr_go            = wr_en;
  assign wr_idx           = sel_idx;
  assign seq_busy         = 1'b0;
  assign seq_done         = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= wr_go;
    end
  end
`endif

  // One-hot slot write enable; at most one slot changes per cycle
  always_comb begin
    slot_we = '0;
    if (wr_go) begin
      unique case (wr_idx)
        3'd0:    slot_we[0] = 1'b1;
        3'd1:    slot_we[1] = 1'b1;
        3'd2:    slot_we[2] = 1'b1;
        3'd3:    slot_we[3] = 1'b1;
        default: slot_we[4] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_u <= '0;
      out_v <= '0;
      out_w <= '0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      if (slot_we[0]) out_u <= DW'(data_in);
      if (slot_we[1]) out_v <= DW'(data_in);
      if (slot_we[2]) out_w <= DW'(data_in);
      if (slot_we[3]) out_x <= DW'(data_in);
      if (slot_we[4]) out_y <= DW'(data_in);
    end
  end

endmodule
